// File: rtl/clk_div_prog.sv
// Programmable integer clock divider (o_clk) with period-start strobe (o_tick); optional exact 50% duty under CLK_DIV_DUTY50_EN.
// Latency: o_clk/o_tick registered one cycle after cnt update; new config applies at the next period boundary (worst case one old period + 1).
// Backpressure: cfg_ready drops while a legal config is staged; cfg_valid is ignored then and must be held by the requester.
module clk_div_prog #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 50,
  parameter int DEF_HIGH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             o_clk,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_a, div_s, div_n, high_n;
  logic             run, pend, err_q, clk_p, tick_q;
  logic             wrap, restart, apply, accept, legal;
  logic             clk_p_n, tick_n;

`ifdef CLK_DIV_DUTY50_EN
  assign legal  = (cfg_div >= TWO);
  assign high_n = div_n >> 1;
`else
  logic [CNT_W-1:0] high_a, high_s;
  assign legal  = (cfg_div >= TWO) && (cfg_high != '0) && (cfg_high < cfg_div);
  assign high_n = apply ? high_s : high_a;
`endif

  // restart covers idle (en low), the first enabled edge after idle, and the wrap.
  always_comb begin
    wrap    = run & en & (cnt == (div_a - ONE));
    restart = ~en | ~run | wrap;
    apply   = pend & restart;
    accept  = cfg_valid & ~pend;
    div_n   = apply ? div_s : div_a;
    cnt_n   = restart ? '0 : (cnt + ONE);
    clk_p_n = en & (cnt_n < high_n);
    tick_n  = en & (cnt_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      run    <= 1'b0;
      div_a  <= DIV_RST;
      div_s  <= DIV_RST;
      pend   <= 1'b0;
      err_q  <= 1'b0;
      clk_p  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      run    <= en;
      clk_p  <= clk_p_n;
      tick_q <= tick_n;
      if (apply) begin
        div_a <= div_s;
        pend  <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          div_s <= cfg_div;
          pend  <= 1'b1;
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  // Half-cycle extension for odd ratios; OR of two flops that never toggle together.
  logic clk_neg;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clk_neg <= 1'b0;
    else        clk_neg <= en & clk_p & div_a[0];
  end

  assign o_clk = clk_p | clk_neg;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_a <= HIGH_RST;
      high_s <= HIGH_RST;
    end else if (apply) begin
      high_a <= high_s;
    end else if (accept && legal) begin
      high_s <= cfg_high;
    end
  end

  assign o_clk = clk_p;
`endif

  assign o_tick    = tick_q;
  assign cfg_ready = ~pend;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: period/high-time measurement, config handshake, en gating, reset.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div = '0;
  logic [15:0] cfg_high = '0;
  logic        cfg_err;
  logic        o_clk;
  logic        o_tick;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_prog #(.CNT_W(16), .DEF_DIV(50), .DEF_HIGH(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .o_clk     (o_clk),
    .o_tick    (o_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Applied at a negedge, accepted on the following posedge; returns at the next negedge.
  task automatic send_cfg(input logic [15:0] d, input logic [15:0] h);
    cfg_div   = d;
    cfg_high  = h;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Waits (bounded) for a tick, then counts one full period and its high cycles.
  task automatic measure(input string tag, input int exp_p, input int exp_h);
    int w = 0;
    int p = 0;
    int h = 0;
    while (!o_tick && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_tick_seen"}, 32'(o_tick), 1);
    do begin
      h += int'(o_clk);
      p++;
      @(negedge clk);
    end while (!o_tick && p < 300);
    check_eq({tag, "_period"}, p, exp_p);
    check_eq({tag, "_high"}, h, exp_h);
  endtask

`ifdef CLK_DIV_DUTY50_EN
  // Counts o_clk high samples at both clk phases over one period from a tick.
  task automatic measure_half(input string tag, input int n, input int exp_halves);
    int w = 0;
    int h = 0;
    while (!o_tick && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_tick_seen"}, 32'(o_tick), 1);
    for (int i = 0; i < n; i++) begin
      #1 h += int'(o_clk);
      @(posedge clk);
      #1 h += int'(o_clk);
      @(negedge clk);
    end
    check_eq({tag, "_half_high"}, h, exp_halves);
  endtask
`endif

  initial begin
    int n;
    logic last_rdy;

    // Reset state
    en = 1'b1;
    #1;
    check_eq("rst_o_clk", 32'(o_clk), 0);
    check_eq("rst_o_tick", 32'(o_tick), 0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 1);
    check_eq("rst_cfg_err", 32'(cfg_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t1_first_tick", 32'(o_tick), 1);
    check_eq("t1_first_clk", 32'(o_clk), 1);

`ifndef CLK_DIV_DUTY50_EN
    measure("t1_def", 50, 25);
    check_eq("t1_err", 32'(cfg_err), 0);

    // Legal N=7 H=3 accepted at cnt=10; old period must finish first
    repeat (10) @(negedge clk);
    send_cfg(16'd7, 16'd3);
    check_eq("t2_ready_low", 32'(cfg_ready), 0);
    n = 0;
    last_rdy = 1'bx;
    while (!o_tick && n < 100) begin
      last_rdy = cfg_ready;
      @(negedge clk);
      n++;
    end
    check_eq("t2_cycles_to_wrap", n, 39);
    check_eq("t2_ready_before_apply", 32'(last_rdy), 0);
    check_eq("t2_ready_at_apply", 32'(cfg_ready), 1);
    measure("t2_p1", 7, 3);
    measure("t2_p2", 7, 3);

    // Illegal configs: sticky error, no staging
    send_cfg(16'd1, 16'd1);
    check_eq("t3_err_n1", 32'(cfg_err), 1);
    check_eq("t3_ready_n1", 32'(cfg_ready), 1);
    send_cfg(16'd9, 16'd9);
    check_eq("t3_err_h9", 32'(cfg_err), 1);
    check_eq("t3_ready_h9", 32'(cfg_ready), 1);
    measure("t3_keep", 7, 3);
    send_cfg(16'd4, 16'd2);
    check_eq("t3_err_clear", 32'(cfg_err), 0);
    check_eq("t3_ready_pend", 32'(cfg_ready), 0);
    measure("t3_new", 4, 2);

    // en=0 at cnt=10 of a 50-cycle period
    send_cfg(16'd50, 16'd25);
    measure("t4_back50", 50, 25);
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_eq("t4_off_clk", 32'(o_clk), 0);
    check_eq("t4_off_tick", 32'(o_tick), 0);
    repeat (3) @(negedge clk);
    check_eq("t4_idle_clk", 32'(o_clk), 0);
    en = 1'b1;
    @(negedge clk);
    check_eq("t4_on_tick", 32'(o_tick), 1);
    check_eq("t4_on_clk", 32'(o_clk), 1);
    measure("t4_full", 50, 25);

    // Reset with a config pending drops it
    repeat (5) @(negedge clk);
    send_cfg(16'd10, 16'd5);
    check_eq("t5_pend", 32'(cfg_ready), 0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_clk", 32'(o_clk), 0);
    check_eq("t5_rst_tick", 32'(o_tick), 0);
    check_eq("t5_rst_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_restart_tick", 32'(o_tick), 1);
    measure("t5_def", 50, 25);

    // Boundaries: minimum ratio, maximum high time
    send_cfg(16'd2, 16'd1);
    measure("t6_n2", 2, 1);
    measure("t6_n2b", 2, 1);
    send_cfg(16'd3, 16'd2);
    measure("t6_n3h2", 3, 2);
    send_cfg(16'd3, 16'd0);
    check_eq("t6_h0_err", 32'(cfg_err), 1);

    // With en low a staged config applies on the next edge
    en = 1'b0;
    @(negedge clk);
    send_cfg(16'd6, 16'd1);
    check_eq("t7_pend", 32'(cfg_ready), 0);
    @(negedge clk);
    check_eq("t7_applied", 32'(cfg_ready), 1);
    en = 1'b1;
    @(negedge clk);
    check_eq("t7_tick", 32'(o_tick), 1);
    measure("t7_n6", 6, 1);
`else
    // Exact 50% duty: odd ratio uses the half-cycle extension
    send_cfg(16'd5, 16'd0);
    check_eq("d_err", 32'(cfg_err), 0);
    measure("d_n5", 5, 2);
    measure_half("d_n5", 5, 5);
    measure("d_n5_tick", 5, 2);
    send_cfg(16'd6, 16'd0);
    measure("d_n6", 6, 3);
    measure_half("d_n6", 6, 6);
    send_cfg(16'd1, 16'd0);
    check_eq("d_err_n1", 32'(cfg_err), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
